bcd_to_bin: RTL and testbench

BCD_TO_BIN -- requirements
Module: bcd_to_bin

---
 rtl/bcd_to_bin_pkg.sv | 17 +
 rtl/bcd_to_bin_check8_minus3.sv | 12 +
 rtl/bcd_to_bin.sv | 98 +++++++++
 tb/tb_bcd_to_bin.sv | 188 ++++++++++++++++++
 4 files changed

// File: rtl/bcd_to_bin_pkg.sv
// Shared constants for the iterative BCD-to-binary converter: default sizes,
// FSM state encoding and the nibble thresholds used by the shift-subtract loop.
package bcd_to_bin_pkg;

  localparam int NDIG_DEF  = 3;
  localparam int BIN_W_DEF = 10;
  localparam int ITER      = BIN_W_DEF;

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_CONV = 2'd1;
  localparam logic [1:0] ST_DONE = 2'd2;

  localparam logic [3:0] NIB_3 = 4'd3;
  localparam logic [3:0] NIB_8 = 4'd8;
  localparam logic [3:0] NIB_9 = 4'd9;

endpackage

// File: rtl/bcd_to_bin_check8_minus3.sv
// Per-digit correction for the right-shifting BCD-to-binary loop: undoes the
// add-3 step of double-dabble by taking 3 off any nibble that reached 8.
module check8_minus3
  import bcd_to_bin_pkg::*;
(
  input  logic [3:0] nib,
  output logic [3:0] nib_adj
);

  assign nib_adj = (nib >= NIB_8) ? nib - NIB_3 : nib;

endmodule

// File: rtl/bcd_to_bin.sv
// Iterative BCD-to-binary converter: one right shift plus per-digit -3
// correction per clock, BIN_W iterations per conversion.
module bcd_to_bin
  import bcd_to_bin_pkg::*;
#(
  parameter int NDIG  = NDIG_DEF,
  parameter int BIN_W = BIN_W_DEF
) (
  input  logic              sys_clk,
  input  logic              sys_rst_n,
  input  logic              start,
  input  logic [4*NDIG-1:0] bcd_in,
  output logic              busy,
  output logic              done,
  output logic [BIN_W-1:0]  bin_out,
  output logic              err
);

  localparam int BCD_W = 4 * NDIG;
  localparam int CNT_W = (BIN_W > 1) ? $clog2(BIN_W) : 1;
  localparam logic [CNT_W-1:0] LAST = CNT_W'(BIN_W - 1);

  logic [1:0]       state;
  logic [BCD_W-1:0] bcd_sh;
  logic [BIN_W-1:0] bin_sh;
  logic [CNT_W-1:0] cnt;

  logic [BCD_W-1:0] bcd_shift;
  logic [BCD_W-1:0] bcd_corr;
  logic [BIN_W-1:0] bin_shift;
  logic             bad_digit;

  // One iteration: the whole {bcd_sh, bin_sh} register moves right by one,
  // then each BCD nibble is corrected.
  assign bcd_shift = {1'b0, bcd_sh[BCD_W-1:1]};
  assign bin_shift = {bcd_sh[0], bin_sh[BIN_W-1:1]};

  for (genvar g = 0; g < NDIG; g++) begin : g_digit
    check8_minus3 u_fix (
      .nib     (bcd_shift[4*g +: 4]),
      .nib_adj (bcd_corr[4*g +: 4])
    );
  end

  always_comb begin
    bad_digit = 1'b0;
    for (int i = 0; i < NDIG; i++) begin
      if (bcd_in[4*i +: 4] > NIB_9) bad_digit = 1'b1;
    end
  end

  // NOTE: every register here is cleared by the synchronous reset, including
  // the working register, so an aborted conversion leaves no stale data.
  always_ff @(posedge sys_clk) begin
    if (!sys_rst_n) begin
      state   <= ST_IDLE;
      bcd_sh  <= '0;
      bin_sh  <= '0;
      cnt     <= '0;
      bin_out <= '0;
      err     <= 1'b0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (start) begin
            if (bad_digit) begin
              state   <= ST_DONE;
              bin_out <= '0;
              err     <= 1'b1;
            end else begin
              state  <= ST_CONV;
              bcd_sh <= bcd_in;
              bin_sh <= '0;
              cnt    <= '0;
            end
          end
        end
        ST_CONV: begin
          bcd_sh <= bcd_corr;
          bin_sh <= bin_shift;
          cnt    <= cnt + CNT_W'(1);
          // The result is captured from this final iteration's shifted value.
          if (cnt == LAST) begin
            state   <= ST_DONE;
            bin_out <= bin_shift;
            err     <= 1'b0;
          end
        end
        ST_DONE: state <= ST_IDLE;
        default: state <= ST_IDLE;
      endcase
    end
  end

  assign busy = (state == ST_CONV);
  assign done = (state == ST_DONE);

endmodule

// File: tb/tb_bcd_to_bin.sv
// Directed scoreboard bench for bcd_to_bin: expected results are queued at the
// accepting edge and compared when done pulses.
module tb_bcd_to_bin;

  localparam int NDIG  = 3;
  localparam int BIN_W = 10;

  typedef struct {
    logic [BIN_W-1:0] bin;
    logic             err;
    string            tag;
  } exp_t;

  logic              sys_clk   = 1'b0;
  logic              sys_rst_n = 1'b0;
  logic              start     = 1'b0;
  logic [4*NDIG-1:0] bcd_in    = '0;
  logic              busy;
  logic              done;
  logic [BIN_W-1:0]  bin_out;
  logic              err;

  exp_t sb[$];
  int   n_pass  = 0;
  int   n_total = 0;

  bcd_to_bin #(.NDIG(NDIG), .BIN_W(BIN_W)) dut (
    .sys_clk   (sys_clk),
    .sys_rst_n (sys_rst_n),
    .start     (start),
    .bcd_in    (bcd_in),
    .busy      (busy),
    .done      (done),
    .bin_out   (bin_out),
    .err       (err)
  );

  always #5 sys_clk = ~sys_clk;

  task automatic step();
    @(posedge sys_clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed %0d, expected %0d", tag, obs, exp);
  endtask

  function automatic exp_t model(input logic [4*NDIG-1:0] b, input string tag);
    exp_t       e;
    int         v;
    logic [3:0] d;
    v     = 0;
    e.err = 1'b0;
    e.tag = tag;
    for (int i = NDIG - 1; i >= 0; i--) begin
      d = b[4*i +: 4];
      if (d > 4'd9) e.err = 1'b1;
      v = v * 10 + int'(d);
    end
    e.bin = e.err ? '0 : BIN_W'(v);
    return e;
  endfunction

  // Drive one start pulse through the accepting edge and queue the expectation.
  task automatic accept(input logic [4*NDIG-1:0] b, input string tag);
    bcd_in = b;
    start  = 1'b1;
    step();
    start  = 1'b0;
    sb.push_back(model(b, tag));
  endtask

  // Wait (bounded) for done, then compare latency, busy length and result.
  task automatic wait_done(input string tag, input int exp_edges, input int exp_busy);
    int   edges;
    int   busy_cnt;
    exp_t e;
    edges    = 0;
    busy_cnt = 0;
    while (!done && edges < 20) begin
      if (busy) busy_cnt++;
      step();
      edges++;
    end
    check({tag, " done"}, 32'(done), 32'd1);
    check({tag, " latency"}, 32'(edges), 32'(exp_edges));
    check({tag, " busy_cycles"}, 32'(busy_cnt), 32'(exp_busy));
    check({tag, " sb_depth"}, 32'(sb.size()), 32'd1);
    if (sb.size() > 0) begin
      e = sb.pop_front();
      check({e.tag, " bin_out"}, 32'(bin_out), 32'(e.bin));
      check({e.tag, " err"}, 32'(err), 32'(e.err));
    end
  endtask

  initial begin
    exp_t e;

    // Reset state
    step();
    step();
    check("rst busy", 32'(busy), 32'd0);
    check("rst done", 32'(done), 32'd0);
    check("rst bin_out", 32'(bin_out), 32'd0);
    check("rst err", 32'(err), 32'd0);
    sys_rst_n = 1'b1;
    step();

    // Zero, max and mid-range operands
    accept(12'h000, "bcd000");
    check("bcd000 busy_after_accept", 32'(busy), 32'd1);
    wait_done("bcd000", 10, 10);
    step();
    check("bcd000 done_one_cycle", 32'(done), 32'd0);

    accept(12'h999, "bcd999");
    wait_done("bcd999", 10, 10);
    step();

    accept(12'h255, "bcd255");
    wait_done("bcd255", 10, 10);
    bcd_in = 12'h876;
    step();
    step();
    check("bcd255 bin_out_held", 32'(bin_out), 32'd255);

    // Invalid nibble goes straight to DONE with err, then a valid recovery
    accept(12'h9A5, "bcd9A5");
    wait_done("bcd9A5", 0, 0);
    step();
    check("bcd9A5 err_held", 32'(err), 32'd1);
    accept(12'h042, "bcd042");
    wait_done("bcd042", 10, 10);

    // Start held high: operand change during CONV is ignored, next accept
    // follows the done cycle
    step();
    bcd_in = 12'h321;
    start  = 1'b1;
    step();
    sb.push_back(model(12'h321, "hold321"));
    bcd_in = 12'h777;
    wait_done("hold321", 10, 10);
    step();
    check("hold idle_after_done busy", 32'(busy), 32'd0);
    check("hold idle_after_done done", 32'(done), 32'd0);
    step();
    sb.push_back(model(12'h777, "hold777"));
    check("hold777 accepted", 32'(busy), 32'd1);
    start = 1'b0;
    wait_done("hold777", 10, 10);
    step();

    // Reset mid-conversion aborts; first start after release is accepted
    accept(12'h555, "abort555");
    step();
    step();
    step();
    sys_rst_n = 1'b0;
    step();
    sb.delete();
    check("abort busy", 32'(busy), 32'd0);
    check("abort done", 32'(done), 32'd0);
    check("abort bin_out", 32'(bin_out), 32'd0);
    check("abort err", 32'(err), 32'd0);
    sys_rst_n = 1'b1;
    accept(12'h128, "bcd128");
    check("bcd128 first_edge_accept", 32'(busy), 32'd1);
    wait_done("bcd128", 10, 10);

    // A few more digit patterns through the model
    for (int i = 0; i < 4; i++) begin
      logic [11:0] b;
      b = {4'($urandom_range(0, 9)), 4'($urandom_range(0, 9)), 4'($urandom_range(0, 9))};
      step();
      accept(b, $sformatf("rand%03h", b));
      wait_done($sformatf("rand%03h", b), 10, 10);
    end
    step();

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
